// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: IF/ID valid/ready pipeline register with a 2-entry skid buffer, lane masking, flush and stall counter.
module if_id_skid_reg #(
    parameter int                 LANES    = 4,
    parameter int                 PC_W     = 16,
    parameter int                 INST_W   = 16,
    parameter int                 PRED_W   = 1,
    parameter logic [INST_W-1:0]  NOP_INST = '0,
    parameter int                 CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LANES*PC_W-1:0]     pc_in,
    input  logic [LANES*INST_W-1:0]   inst_in,
    input  logic [LANES*PC_W-1:0]     recv_pc_in,
    input  logic [LANES*PRED_W-1:0]   pred_in,
    input  logic [LANES-1:0]          lane_vld_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    output logic [LANES*PC_W-1:0]     pc_out,
    output logic [LANES*INST_W-1:0]   inst_out,
    output logic [LANES*PC_W-1:0]     recv_pc_out,
    output logic [LANES*PRED_W-1:0]   pred_out,
    output logic [LANES-1:0]          lane_vld_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          stall_cycles
);
    localparam int PW = LANES*PC_W;
    localparam int IW = LANES*INST_W;
    localparam int RW = LANES*PRED_W;
    localparam logic [IW-1:0]    NOP_ALL = {LANES{NOP_INST}};
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // State bits double as the slot valids: bit0 = m_v, bit1 = s_v
    typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b11} state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    m_pc, m_rpc, s_pc, s_rpc;
    logic [IW-1:0]    m_inst, s_inst, inst_msk;
    logic [RW-1:0]    m_pred, s_pred;
    logic [LANES-1:0] m_lv, s_lv;
    logic             acc, deq, ld_m_in, ld_m_s, ld_s_in;

    for (genvar i = 0; i < LANES; i++) begin : g_mask
        assign inst_msk[i*INST_W +: INST_W] = lane_vld_in[i] ? inst_in[i*INST_W +: INST_W] : NOP_INST;
    end

    assign in_ready     = ~state[1];
    assign out_valid    = state[0];
    assign acc          = in_valid & in_ready & (|lane_vld_in);
    assign deq          = state[0] & out_ready;
    assign pc_out       = m_pc;
    assign inst_out     = m_inst;
    assign recv_pc_out  = m_rpc;
    assign pred_out     = m_pred;
    assign lane_vld_out = m_lv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_m_in   = 1'b0;
        ld_m_s    = 1'b0;
        ld_s_in   = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    ld_m_in   = acc;
                    state_nxt = acc ? ONE : EMPTY;
                end
                ONE: begin
                    ld_m_in   = acc & deq;
                    ld_s_in   = acc & ~deq;
                    state_nxt = (acc & ~deq) ? FULL : (~acc & deq) ? EMPTY : ONE;
                end
                FULL: begin
                    ld_m_s    = deq;
                    state_nxt = deq ? ONE : FULL;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc   <= '0;
            m_rpc  <= '0;
            m_inst <= NOP_ALL;
            m_pred <= '0;
            m_lv   <= '0;
        end else if (flush) begin
            m_inst <= NOP_ALL;
            m_pred <= '0;
            m_lv   <= '0;
        end else if (ld_m_in) begin
            m_pc   <= pc_in;
            m_rpc  <= recv_pc_in;
            m_inst <= inst_msk;
            m_pred <= pred_in;
            m_lv   <= lane_vld_in;
        end else if (ld_m_s) begin
            m_pc   <= s_pc;
            m_rpc  <= s_rpc;
            m_inst <= s_inst;
            m_pred <= s_pred;
            m_lv   <= s_lv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_pc   <= '0;
            s_rpc  <= '0;
            s_inst <= NOP_ALL;
            s_pred <= '0;
            s_lv   <= '0;
        end else if (flush) begin
            s_inst <= NOP_ALL;
            s_pred <= '0;
            s_lv   <= '0;
        end else if (ld_s_in) begin
            s_pc   <= pc_in;
            s_rpc  <= recv_pc_in;
            s_inst <= inst_msk;
            s_pred <= pred_in;
            s_lv   <= lane_vld_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                                  stall_cycles <= '0;
        else if (state[0] & ~out_ready & ~flush & ~(&stall_cycles)) stall_cycles <= stall_cycles + CNT_ONE;
    end
endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb_if_id_skid_reg: directed scoreboard bench; stimulus queues expected packets, a negedge monitor pops and compares.
module tb_if_id_skid_reg;
    localparam logic [15:0] NOP = 16'hF00D;
    localparam logic [63:0] NOP_ALL = {4{NOP}};

    typedef struct {
        logic [63:0] pc;
        logic [63:0] inst;
        logic [63:0] rpc;
        logic [3:0]  pred;
        logic [3:0]  lv;
    } pkt_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [63:0] pc_in = '0, inst_in = '0, recv_pc_in = '0;
    logic [3:0]  pred_in = '0, lane_vld_in = '0;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [63:0] pc_out, inst_out, recv_pc_out;
    logic [3:0]  pred_out, lane_vld_out, stall_cycles;

    int   checks = 0, failures = 0, pops = 0, ready_waits = 0;
    pkt_t q[$];
    pkt_t a, b, c;

    if_id_skid_reg #(.LANES(4), .PC_W(16), .INST_W(16), .PRED_W(1), .NOP_INST(NOP), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .inst_in(inst_in), .recv_pc_in(recv_pc_in),
        .pred_in(pred_in), .lane_vld_in(lane_vld_in), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .pc_out(pc_out), .inst_out(inst_out), .recv_pc_out(recv_pc_out),
        .pred_out(pred_out), .lane_vld_out(lane_vld_out), .out_valid(out_valid),
        .out_ready(out_ready), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pop pc=%h inst=%h", pc_out, inst_out);
            end else begin
                pkt_t e;
                e = q.pop_front();
                pops++;
                if ({pc_out, inst_out, recv_pc_out, pred_out, lane_vld_out} !== {e.pc, e.inst, e.rpc, e.pred, e.lv}) begin
                    failures++;
                    $display("FAIL pop_packet actual pc=%h inst=%h rpc=%h pred=%h lv=%h required pc=%h inst=%h rpc=%h pred=%h lv=%h",
                             pc_out, inst_out, recv_pc_out, pred_out, lane_vld_out, e.pc, e.inst, e.rpc, e.pred, e.lv);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic pkt_t mk(input logic [15:0] base, input logic [3:0] m, input logic [63:0] inst);
        pkt_t p;
        p.pc   = {base + 16'd3, base + 16'd2, base + 16'd1, base};
        p.rpc  = p.pc ^ {4{16'h8000}};
        p.inst = inst;
        p.pred = base[3:0] ^ 4'h5;
        p.lv   = m;
        return p;
    endfunction

    task automatic drive(input pkt_t p, input pkt_t e, input bit store);
        pc_in = p.pc; inst_in = p.inst; recv_pc_in = p.rpc; pred_in = p.pred; lane_vld_in = p.lv;
        in_valid = 1'b1;
        if (store) q.push_back(e);
    endtask

    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
        end
        if (n > 0) ready_waits++;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
        q.delete();
        @(negedge clk);
        pops = 0; ready_waits = 0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_stall"}, stall_cycles, 0);
        chk({tag, "_inst"}, inst_out, NOP_ALL);
        chk({tag, "_pc_rpc"}, {pc_out ^ recv_pc_out, 4'h0, pred_out | lane_vld_out}, 0);
    endtask

    initial begin
        // 1: streaming at full rate
        out_ready = 1'b1;
        do_reset();
        reset_vals("rst1");
        for (int k = 0; k < 8; k++) begin
            a = mk(16'h0010 + 16'(4*k), 4'hF, {16'h3000 + 16'(k), 16'h2000 + 16'(k), 16'h1000 + 16'(k), 16'h0100 + 16'(k)});
            drive(a, a, 1);
            wait_accept();
            if (k == 0) chk("latency1", out_valid, 1);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("stream_ready_waits", ready_waits, 0);
        chk("stream_pops", pops, 8);
        chk("stream_stall", stall_cycles, 0);
        chk("stream_drained", out_valid, 0);

        // 2: backpressure into the skid slot
        do_reset();
        a = mk(16'h0A00, 4'hF, 64'h0A03_0A02_0A01_0A00);
        b = mk(16'h0B00, 4'hF, 64'h0B03_0B02_0B01_0B00);
        c = mk(16'h0C00, 4'hF, 64'h0C03_0C02_0C01_0C00);
        drive(a, a, 1); wait_accept();
        out_ready = 1'b0;
        drive(b, b, 1); wait_accept();
        chk("skid_in_ready", in_ready, 0);
        chk("skid_head", pc_out, a.pc);
        drive(c, c, 1);
        repeat (2) begin @(posedge clk); #1; end
        chk("skid_stall3", stall_cycles, 3);
        chk("skid_hold_ready", in_ready, 0);
        out_ready = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        chk("skid_pops2", pops, 2);
        @(posedge clk); #1;
        chk("skid_pops3", pops, 3);
        chk("skid_stall_final", stall_cycles, 3);

        // 3: lane masking and all-zero mask drop
        do_reset();
        out_ready = 1'b0;
        a = mk(16'h0300, 4'b0101, 64'hAAAA_BBBB_CCCC_DDDD);
        b = a; b.inst = {NOP, 16'hBBBB, NOP, 16'hDDDD};
        drive(a, b, 1); wait_accept();
        chk("mask_inst", inst_out, {NOP, 16'hBBBB, NOP, 16'hDDDD});
        chk("mask_lv", lane_vld_out, 4'b0101);
        c = mk(16'h0400, 4'b0000, 64'h1111_2222_3333_4444);
        drive(c, c, 0); wait_accept();
        in_valid = 1'b0;
        chk("zero_mask_ready", in_ready, 1);
        chk("zero_mask_head", pc_out, a.pc);
        chk("zero_mask_valid", out_valid, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("mask_pops", pops, 1);
        chk("mask_drained", out_valid, 0);

        // 4: flush while FULL
        do_reset();
        out_ready = 1'b0;
        a = mk(16'h4000, 4'hF, 64'h4444_4443_4442_4441);
        b = mk(16'h5000, 4'hF, 64'h5555_5553_5552_5551);
        c = mk(16'h6000, 4'hF, 64'h6666_6663_6662_6661);
        drive(a, a, 1); wait_accept();
        drive(b, b, 1); wait_accept();
        chk("full_ready", in_ready, 0);
        drive(c, c, 0);
        q.delete();
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_ready", in_ready, 1);
        chk("flush_inst", inst_out, NOP_ALL);
        chk("flush_lv_pred", {pred_out, lane_vld_out}, 0);
        chk("flush_pc_hold", pc_out, a.pc);
        chk("flush_stall", stall_cycles, 1);
        repeat (2) begin @(posedge clk); #1; end
        chk("flush_lost", {31'd0, out_valid, 32'(pops)}, 0);

        // 5: stall counter saturation
        do_reset();
        out_ready = 1'b0;
        a = mk(16'h7000, 4'hF, 64'h7777_7776_7775_7774);
        drive(a, a, 1); wait_accept();
        in_valid = 1'b0;
        repeat (14) begin @(posedge clk); #1; end
        chk("stall14", stall_cycles, 14);
        repeat (6) begin @(posedge clk); #1; end
        chk("stall_sat", stall_cycles, 4'hF);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("sat_pop", pops, 1);
        chk("sat_hold", stall_cycles, 4'hF);

        // 6: asynchronous reset mid-cycle while FULL
        do_reset();
        out_ready = 1'b0;
        a = mk(16'h8000, 4'hF, 64'h8888_8887_8886_8885);
        b = mk(16'h9000, 4'hF, 64'h9999_9998_9997_9996);
        drive(a, a, 1); wait_accept();
        drive(b, b, 1); wait_accept();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        q.delete();
        #1 reset_vals("async");
        #3 rst_n = 1'b1;
        pops = 0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        c = mk(16'hC000, 4'b1001, 64'hCCC3_CCC2_CCC1_CCC0);
        b = c; b.inst = {16'hCCC3, NOP, NOP, 16'hCCC0};
        drive(c, b, 1); wait_accept();
        in_valid = 1'b0;
        chk("post_rst_latency", out_valid, 1);
        @(posedge clk); #1;
        chk("post_rst_pop", pops, 1);
        chk("queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
